hazard_pipe_ctrl: RTL and testbench
===================================

Name: hazard_pipe_ctrl

Overview:
- Pipeline hazard controller sitting directly upstream of forwardingUnit in the 5-stage MIPS datapath.
- Carries destination-register metadata (rd, regWrite, memRead) through the DX, XM and MW pipeline stages; produces the rd_XM/rd_MW/regWrite_XM/regWrite_MW signals that forwardingUnit consumes.
- Detects load-use hazards, multi-cycle data-memory waits and taken branches.
- Drives stall, bubble and flush controls for the fetch, decode and execute stages.

Parameters:
- TIMEOUT, 8, max MEM_WAIT cycles before memTimeout sets.
- CNT_W, 16, width of the saturating stall performance counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- valid_FD  in  1  decode stage holds a real instruction.
- rs_FD  in  5  decode source register rs.
- rt_FD  in  5  decode source register rt.
- useRs_FD  in  1  decode instruction reads rs.
- useRt_FD  in  1  decode instruction reads rt.
- rd_FD  in  5  decode destination register.
- regWrite_FD  in  1  decode instruction writes the register file.
- memRead_FD  in  1  decode instruction is a load.
- branchTaken_DX  in  1  branch resolved taken in EX.
- dmemReady  in  1  data memory completes the access in XM this cycle.
- stall_F  out  1  hold PC.
- stall_D  out  1  hold IF/ID register.
- stall_X  out  1  hold ID/EX and EX/MEM registers.
- flush_D  out  1  squash IF/ID contents.
- rd_DX, rd_XM, rd_MW  out  5 each  tracked destinations.
- regWrite_DX, regWrite_XM, regWrite_MW  out  1 each  tracked write enables.
- memRead_DX, memRead_XM  out  1 each  tracked load flags.
- inMemWait  out  1  FSM is in MEM_WAIT.
- memTimeout  out  1  sticky error flag.
- stallCount  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Reset (rst_n low, asynchronous): all tracked rd/regWrite/memRead registers = 0, FSM = RUN, wait counter = 0, memTimeout = 0, stallCount = 0. stall_*/flush_D are forced 0 while rst_n is low.

FSM states:
- RUN to MEM_WAIT when memRead_XM & !dmemReady.
- MEM_WAIT to RUN on dmemReady.
- In MEM_WAIT, the wait counter increments each cycle. When it reaches TIMEOUT, memTimeout sets and stays set until reset; the FSM stays in MEM_WAIT.

Hazard conditions (combinational):
- memStall = memRead_XM & !dmemReady. This holds in both RUN and MEM_WAIT, so the stall begins in the first cycle of the wait.
- loadUse = valid_FD & memRead_DX & regWrite_DX & (rd_DX≠0) & ((useRs_FD & rs_FD==rd_DX) | (useRt_FD & rt_FD==rd_DX)).

Priority, one action per cycle:
1. memStall: stall_F = stall_D = stall_X = 1. DX and XM registers hold. MW loads a bubble (rd_MW = 0, regWrite_MW = 0).
2. branchTaken_DX: flush_D = 1, no stall. The DX slot loads a bubble because the FD instruction is squashed. Any coincident loadUse is ignored.
3. loadUse: stall_F = stall_D = 1 for exactly one cycle. The DX slot loads a bubble; XM<=DX and MW<=XM advance. The next cycle's match is against the MEM-stage load, which forwardingUnit covers via the MW path.
4. Otherwise: DX<=FD fields, gated by valid_FD (invalid gives a bubble). XM<=DX, MW<=XM.

Other rules:
- A branch held in DX during memStall takes effect in the first cycle after the wait ends.
- A bubble means rd = 0, regWrite = 0, memRead = 0.
- stallCount increments on any cycle with stall_F = 1 and saturates at all-ones.
- The wait counter clears on leaving MEM_WAIT.
- Latency: metadata advances one stage per unstalled cycle. rd_FD appears on rd_MW three cycles after acceptance.

Decomposition:
- Shared pipeline package holds:
  - FSM state encoding (RUN = 0, MEM_WAIT = 1).
  - Register-index width constant (5).
  - Bubble constant for the {rd, regWrite, memRead} bundle.
- One sub-module, hazard_stage_reg: a stage metadata register with hold and bubble controls, instantiated for DX, XM and MW.

Test Plan:
1. Load-use: lw with rd_FD = 5, then next instruction with useRs, rs_FD = 5 -> stall_F = stall_D = 1 for one cycle; regWrite_DX = 0 the following cycle; rd_XM = 5 next; stallCount = 1.
2. rd = 0 load (lw $0), then consumer with rs = 0 -> no stall; metadata flows to rd_MW = 0, regWrite_MW = 1 in three cycles.
3. Memory wait: load reaches XM with dmemReady = 0 for 3 cycles -> stall_F/D/X = 1 for 3 cycles, inMemWait = 1, regWrite_MW = 0 during the wait; the load appears at MW on the cycle after ready; stallCount = 3.
4. Branch plus load-use: branchTaken_DX = 1 while a load-use match is present in FD -> flush_D = 1, stall_F = 0, DX bubble inserted.
5. Timeout: dmemReady held 0 for TIMEOUT + 2 cycles -> memTimeout sets at cycle 8 and stays 1 after dmemReady returns.
6. Reset mid-wait: rst_n low during MEM_WAIT -> inMemWait = 0, all stalls = 0, all rd/regWrite = 0, stallCount = 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/hazard_pipe_pkg.sv
// Shared definitions for the hazard controller: FSM encoding, register-index
// width and the per-stage destination metadata bundle.
package hazard_pipe_pkg;

  localparam int unsigned REG_W = 5;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_t;

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic             reg_write;
    logic             mem_read;
  } stage_meta_t;

  localparam stage_meta_t BUBBLE = '0;

endpackage

// File: rtl/hazard_stage_reg.sv
// One pipeline stage of destination metadata; hold wins over bubble, bubble
// wins over loading the upstream stage.
module hazard_stage_reg
  import hazard_pipe_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hold,
  input  logic        bubble,
  input  stage_meta_t d,
  output stage_meta_t q
);

  // NOTE: sequential state uses non-blocking assignment and an asynchronous
  // active-low reset so every stage clears at once without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      q <= BUBBLE;
    else if (hold)   q <= q;
    else if (bubble) q <= BUBBLE;
    else             q <= d;
  end

endmodule

// File: rtl/hazard_pipe_ctrl.sv
// Load-use / memory-wait / taken-branch hazard control for a 5-stage MIPS
// pipeline, plus the DX/XM/MW destination tracking consumed by forwarding.
module hazard_pipe_ctrl
  import hazard_pipe_pkg::*;
#(
  parameter int unsigned TIMEOUT = 8,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_FD,
  input  logic [REG_W-1:0] rs_FD,
  input  logic [REG_W-1:0] rt_FD,
  input  logic             useRs_FD,
  input  logic             useRt_FD,
  input  logic [REG_W-1:0] rd_FD,
  input  logic             regWrite_FD,
  input  logic             memRead_FD,
  input  logic             branchTaken_DX,
  input  logic             dmemReady,
  output logic             stall_F,
  output logic             stall_D,
  output logic             stall_X,
  output logic             flush_D,
  output logic [REG_W-1:0] rd_DX,
  output logic [REG_W-1:0] rd_XM,
  output logic [REG_W-1:0] rd_MW,
  output logic             regWrite_DX,
  output logic             regWrite_XM,
  output logic             regWrite_MW,
  output logic             memRead_DX,
  output logic             memRead_XM,
  output logic             inMemWait,
  output logic             memTimeout,
  output logic [CNT_W-1:0] stallCount
);

  localparam int unsigned WCNT_W = $clog2(TIMEOUT + 1);

  stage_meta_t meta_fd, meta_dx, meta_xm, meta_mw;
  hz_state_t   state, state_nxt;
  logic [WCNT_W-1:0] wait_cnt;
  logic mem_stall, load_use, branch, dx_bubble;

  assign meta_fd = '{rd: rd_FD, reg_write: regWrite_FD, mem_read: memRead_FD};

  assign mem_stall = meta_xm.mem_read & ~dmemReady;
  assign load_use  = valid_FD & meta_dx.mem_read & meta_dx.reg_write &
                     (meta_dx.rd != '0) &
                     ((useRs_FD & (rs_FD == meta_dx.rd)) |
                      (useRt_FD & (rt_FD == meta_dx.rd)));
  assign branch    = branchTaken_DX & ~mem_stall;

  // Controls are gated by rst_n so they drop the instant reset asserts.
  assign stall_F = rst_n & (mem_stall | (load_use & ~branchTaken_DX));
  assign stall_D = stall_F;
  assign stall_X = rst_n & mem_stall;
  assign flush_D = rst_n & branch;

  assign dx_bubble = branchTaken_DX | load_use | ~valid_FD;

  hazard_stage_reg u_dx (
    .clk(clk), .rst_n(rst_n), .hold(mem_stall), .bubble(dx_bubble),
    .d(meta_fd), .q(meta_dx)
  );

  hazard_stage_reg u_xm (
    .clk(clk), .rst_n(rst_n), .hold(mem_stall), .bubble(1'b0),
    .d(meta_dx), .q(meta_xm)
  );

  hazard_stage_reg u_mw (
    .clk(clk), .rst_n(rst_n), .hold(1'b0), .bubble(mem_stall),
    .d(meta_xm), .q(meta_mw)
  );

  assign rd_DX       = meta_dx.rd;
  assign rd_XM       = meta_xm.rd;
  assign rd_MW       = meta_mw.rd;
  assign regWrite_DX = meta_dx.reg_write;
  assign regWrite_XM = meta_xm.reg_write;
  assign regWrite_MW = meta_mw.reg_write;
  assign memRead_DX  = meta_dx.mem_read;
  assign memRead_XM  = meta_xm.mem_read;
  assign inMemWait   = (state == MEM_WAIT);

  // NOTE: always_comb assigns a default first so no path infers a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:      if (mem_stall) state_nxt = MEM_WAIT;
      MEM_WAIT: if (dmemReady) state_nxt = RUN;
      default:  state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      wait_cnt   <= '0;
      memTimeout <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == MEM_WAIT && dmemReady) begin
        wait_cnt <= '0;
      end else if (state == MEM_WAIT) begin
        if (wait_cnt != WCNT_W'(TIMEOUT)) wait_cnt <= wait_cnt + 1'b1;
        if (wait_cnt == WCNT_W'(TIMEOUT - 1)) memTimeout <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             stallCount <= '0;
    else if (stall_F && stallCount != '1)  stallCount <= stallCount + 1'b1;
  end

endmodule

// File: tb/tb_hazard_pipe_ctrl.sv
// Directed, table-driven bench for hazard_pipe_ctrl plus hand-written
// memory-timeout and reset-during-wait sequences.
module tb_hazard_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid_FD, useRs_FD, useRt_FD, regWrite_FD, memRead_FD;
  logic [4:0] rs_FD, rt_FD, rd_FD;
  logic       branchTaken_DX, dmemReady;
  logic       stall_F, stall_D, stall_X, flush_D;
  logic [4:0] rd_DX, rd_XM, rd_MW;
  logic       regWrite_DX, regWrite_XM, regWrite_MW, memRead_DX, memRead_XM;
  logic       inMemWait, memTimeout;
  logic [15:0] stallCount;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hazard_pipe_ctrl #(.TIMEOUT(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .valid_FD(valid_FD), .rs_FD(rs_FD), .rt_FD(rt_FD),
    .useRs_FD(useRs_FD), .useRt_FD(useRt_FD), .rd_FD(rd_FD),
    .regWrite_FD(regWrite_FD), .memRead_FD(memRead_FD),
    .branchTaken_DX(branchTaken_DX), .dmemReady(dmemReady),
    .stall_F(stall_F), .stall_D(stall_D), .stall_X(stall_X), .flush_D(flush_D),
    .rd_DX(rd_DX), .rd_XM(rd_XM), .rd_MW(rd_MW),
    .regWrite_DX(regWrite_DX), .regWrite_XM(regWrite_XM), .regWrite_MW(regWrite_MW),
    .memRead_DX(memRead_DX), .memRead_XM(memRead_XM),
    .inMemWait(inMemWait), .memTimeout(memTimeout), .stallCount(stallCount)
  );

  typedef struct {
    logic       valid;
    logic [4:0] rs, rt;
    logic       use_rs, use_rt;
    logic [4:0] rd;
    logic       rw, mr, br, rdy;
    logic [3:0] e_ctl;              // {stall_F, stall_D, stall_X, flush_D}
    logic [4:0] e_rd_dx, e_rd_xm, e_rd_mw;
    logic [2:0] e_rw;               // {DX, XM, MW}
    logic [1:0] e_mr;               // {DX, XM}
    logic       e_wait;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic valid, input logic [4:0] rs, input logic [4:0] rt,
    input logic use_rs, input logic use_rt, input logic [4:0] rd,
    input logic rw, input logic mr, input logic br, input logic rdy,
    input logic [3:0] ctl, input logic [4:0] rdx, input logic [4:0] rxm,
    input logic [4:0] rmw, input logic [2:0] erw, input logic [1:0] emr,
    input logic ewait, input logic [15:0] ecnt);
    vec_t v;
    v.valid = valid; v.rs = rs; v.rt = rt; v.use_rs = use_rs; v.use_rt = use_rt;
    v.rd = rd; v.rw = rw; v.mr = mr; v.br = br; v.rdy = rdy;
    v.e_ctl = ctl; v.e_rd_dx = rdx; v.e_rd_xm = rxm; v.e_rd_mw = rmw;
    v.e_rw = erw; v.e_mr = emr; v.e_wait = ewait; v.e_cnt = ecnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    valid_FD = v.valid; rs_FD = v.rs; rt_FD = v.rt; useRs_FD = v.use_rs;
    useRt_FD = v.use_rt; rd_FD = v.rd; regWrite_FD = v.rw; memRead_FD = v.mr;
    branchTaken_DX = v.br; dmemReady = v.rdy;
  endtask

  // Applies one input set for one clock without checking.
  task automatic step(input vec_t v);
    @(negedge clk);
    drive(v);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [19:0] meta_now();
    return {rd_DX, rd_XM, rd_MW, regWrite_DX, regWrite_XM, regWrite_MW,
            memRead_DX, memRead_XM};
  endfunction

  vec_t idle, lw, v;

  initial begin
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    drive(idle);
    #12;
    check("reset_ctl", {stall_F, stall_D, stall_X, flush_D}, 4'b0);
    check("reset_meta", meta_now(), 20'b0);
    check("reset_misc", {inMemWait, memTimeout, stallCount}, 18'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // valid rs rt urs urt rd rw mr br rdy | ctl rd_dx rd_xm rd_mw rw mr wait cnt
    // load-use on rs
    vecs.push_back(mk(1, 1, 0, 1, 0,  5, 1, 1, 0, 1, 4'b0000,  5,  0,  0, 3'b100, 2'b10, 0, 0));
    vecs.push_back(mk(1, 5, 0, 1, 0,  7, 1, 0, 0, 1, 4'b1100,  0,  5,  0, 3'b010, 2'b01, 0, 1));
    vecs.push_back(mk(1, 5, 0, 1, 0,  7, 1, 0, 0, 1, 4'b0000,  7,  0,  5, 3'b101, 2'b00, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0,  9, 1, 1, 0, 1, 4'b0000,  0,  7,  0, 3'b010, 2'b00, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 4'b0000,  0,  0,  7, 3'b001, 2'b00, 0, 1));
    // lw $0 then consumer of $0: no stall
    vecs.push_back(mk(1, 1, 0, 1, 0,  0, 1, 1, 0, 1, 4'b0000,  0,  0,  0, 3'b100, 2'b10, 0, 1));
    vecs.push_back(mk(1, 0, 0, 1, 0,  8, 1, 0, 0, 1, 4'b0000,  8,  0,  0, 3'b110, 2'b01, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 4'b0000,  0,  8,  0, 3'b011, 2'b00, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 4'b0000,  0,  0,  8, 3'b001, 2'b00, 0, 1));
    // memory wait of 3 cycles
    vecs.push_back(mk(1, 1, 0, 1, 0,  3, 1, 1, 0, 1, 4'b0000,  3,  0,  0, 3'b100, 2'b10, 0, 1));
    vecs.push_back(mk(1, 1, 0, 1, 0,  4, 1, 0, 0, 1, 4'b0000,  4,  3,  0, 3'b110, 2'b01, 0, 1));
    vecs.push_back(mk(1, 2, 0, 1, 0,  6, 1, 0, 0, 0, 4'b1110,  4,  3,  0, 3'b110, 2'b01, 1, 2));
    vecs.push_back(mk(1, 2, 0, 1, 0,  6, 1, 0, 0, 0, 4'b1110,  4,  3,  0, 3'b110, 2'b01, 1, 3));
    vecs.push_back(mk(1, 2, 0, 1, 0,  6, 1, 0, 0, 0, 4'b1110,  4,  3,  0, 3'b110, 2'b01, 1, 4));
    vecs.push_back(mk(1, 2, 0, 1, 0,  6, 1, 0, 0, 1, 4'b0000,  6,  4,  3, 3'b111, 2'b00, 0, 4));
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 4'b0000,  0,  6,  4, 3'b011, 2'b00, 0, 4));
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 4'b0000,  0,  0,  6, 3'b001, 2'b00, 0, 4));
    // branch taken coincident with load-use: flush wins
    vecs.push_back(mk(1, 1, 0, 1, 0,  5, 1, 1, 0, 1, 4'b0000,  5,  0,  0, 3'b100, 2'b10, 0, 4));
    vecs.push_back(mk(1, 5, 0, 1, 0,  7, 1, 0, 1, 1, 4'b0001,  0,  5,  0, 3'b010, 2'b01, 0, 4));
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 4'b0000,  0,  0,  5, 3'b001, 2'b00, 0, 4));
    // load-use through rt only
    vecs.push_back(mk(1, 1, 0, 1, 0,  9, 1, 1, 0, 1, 4'b0000,  9,  0,  0, 3'b100, 2'b10, 0, 4));
    vecs.push_back(mk(1, 9, 9, 0, 1, 10, 1, 0, 0, 1, 4'b1100,  0,  9,  0, 3'b010, 2'b01, 0, 5));
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 4'b0000,  0,  0,  9, 3'b001, 2'b00, 0, 5));
    // matching register numbers but not read: no stall
    vecs.push_back(mk(1, 1, 0, 1, 0, 11, 1, 1, 0, 1, 4'b0000, 11,  0,  0, 3'b100, 2'b10, 0, 5));
    vecs.push_back(mk(1,11,11, 0, 0, 12, 1, 0, 0, 1, 4'b0000, 12, 11,  0, 3'b110, 2'b01, 0, 5));
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 4'b0000,  0, 12, 11, 3'b011, 2'b00, 0, 5));
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 4'b0000,  0,  0, 12, 3'b001, 2'b00, 0, 5));
    // branch held in DX during a memory wait takes effect once the wait ends
    vecs.push_back(mk(1, 1, 0, 1, 0,  2, 1, 1, 0, 1, 4'b0000,  2,  0,  0, 3'b100, 2'b10, 0, 5));
    vecs.push_back(mk(1, 1, 0, 1, 0,  0, 0, 0, 0, 1, 4'b0000,  0,  2,  0, 3'b010, 2'b01, 0, 5));
    vecs.push_back(mk(1, 3, 0, 1, 0, 13, 1, 0, 1, 0, 4'b1110,  0,  2,  0, 3'b010, 2'b01, 1, 6));
    vecs.push_back(mk(1, 3, 0, 1, 0, 13, 1, 0, 1, 1, 4'b0001,  0,  0,  2, 3'b001, 2'b00, 0, 6));
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 4'b0000,  0,  0,  0, 3'b000, 2'b00, 0, 6));

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      check($sformatf("v%0d_ctl", i), {stall_F, stall_D, stall_X, flush_D}, vecs[i].e_ctl);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_meta", i), meta_now(),
            {vecs[i].e_rd_dx, vecs[i].e_rd_xm, vecs[i].e_rd_mw, vecs[i].e_rw, vecs[i].e_mr});
      check($sformatf("v%0d_wait_cnt", i), {inMemWait, stallCount}, {vecs[i].e_wait, vecs[i].e_cnt});
    end
    check("no_timeout_yet", memTimeout, 1'b0);

    // Timeout: load stuck in XM for TIMEOUT+2 cycles
    lw = mk(1, 1, 0, 1, 0, 1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(lw);
    step(idle);
    v = idle;
    v.rdy = 1'b0;
    for (int c = 0; c < 4; c++) step(v);
    check("timeout_early", {inMemWait, memTimeout}, 2'b10);
    for (int c = 0; c < 6; c++) step(v);
    check("timeout_set", {inMemWait, memTimeout, stall_X}, 3'b111);
    check("timeout_cnt", stallCount, 16'd16);
    step(idle);
    check("timeout_sticky", {inMemWait, memTimeout, rd_MW, regWrite_MW}, {2'b01, 5'd1, 1'b1});
    step(idle);
    check("timeout_sticky2", {memTimeout, stall_F}, 2'b10);

    // Reset asserted during a wait clears everything without a clock edge
    lw.rd = 5'd4;
    step(lw);
    step(idle);
    step(v);
    step(v);
    check("prereset_wait", {inMemWait, stall_F, rd_XM}, {2'b11, 5'd4});
    @(negedge clk);
    v.br = 1'b1;
    v.valid = 1'b1; v.rs = 5'd4; v.use_rs = 1'b1;
    drive(v);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_ctl", {stall_F, stall_D, stall_X, flush_D}, 4'b0);
    check("rst_meta", meta_now(), 20'b0);
    check("rst_misc", {inMemWait, memTimeout, stallCount}, 18'b0);
    @(negedge clk);
    drive(idle);
    rst_n = 1'b1;
    step(idle);
    check("post_reset", {meta_now(), inMemWait, stallCount}, 37'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
